// File: rtl/m_spi_master_if.sv
// Byte-handshake and SPI pin bundle between the message logic, m_spi_master and the slave link.
interface m_spi_master_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       hold_ss;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       SCLK;
  logic       MOSI;
  logic       SS;
  logic       MISO;

  modport master (
    input  start, tx_byte, hold_ss, MISO,
    output busy, done, rx_byte, SCLK, MOSI, SS
  );

  modport slave (
    output start, tx_byte, hold_ss, MISO,
    input  busy, done, rx_byte, SCLK, MOSI, SS
  );
endinterface

// File: rtl/m_spi_master.sv
// SPI mode-0 master byte engine: MSB-first shift out, LSB-in capture, optional SS hold across bytes.
// Define M_SPI_LOOPBACK_EN to capture the internal MOSI register instead of the MISO pin.
module m_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           btn_reset,
  m_spi_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  localparam logic [7:0] DIV    = 8'(CLK_DIV);
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_div, w_div_nxt;
  logic [3:0] r_half, w_half_nxt;
  logic [7:0] r_tx, w_tx_nxt;
  logic [7:0] r_rx, w_rx_nxt;
  logic [7:0] r_rx_byte, w_rx_byte_nxt;
  logic       r_hold, w_hold_nxt;
  logic       r_sclk, w_sclk_nxt;
  logic       r_mosi, w_mosi_nxt;
  logic       r_ss, w_ss_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       w_tick;
  logic       w_rx_bit;

  assign w_tick = (r_div == '0);

`ifdef M_SPI_LOOPBACK_EN
  assign w_rx_bit = r_mosi;
`else
  assign w_rx_bit = bus.MISO;
`endif

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_half    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_byte <= '0;
      r_hold    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_half    <= w_half_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_byte <= w_rx_byte_nxt;
      r_hold    <= w_hold_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ss      <= w_ss_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_half_nxt    = r_half;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_byte_nxt = r_rx_byte;
    w_hold_nxt    = r_hold;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_ss_nxt      = r_ss;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_tick ? DIV_M1 : r_div - 8'd1;
    end

    unique case (r_state)
      S_IDLE: begin
        w_sclk_nxt = 1'b0;
        if (bus.start) begin
          w_tx_nxt    = bus.tx_byte;
          w_hold_nxt  = bus.hold_ss;
          w_div_nxt   = DIV;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        // Counter still at its load value marks the cycle after acceptance: drive the link then.
        if (r_div == DIV) begin
          w_ss_nxt   = 1'b0;
          w_mosi_nxt = r_tx[7];
          w_busy_nxt = 1'b1;
        end
        if (w_tick) begin
          w_sclk_nxt  = 1'b1;
          w_rx_nxt    = {r_rx[6:0], w_rx_bit};
          w_half_nxt  = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          w_half_nxt = r_half + 4'd1;
          if (r_half == 4'd14) begin
            w_sclk_nxt    = 1'b0;
            w_rx_byte_nxt = r_rx;
            w_done_nxt    = 1'b1;
            if (r_hold) begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end else if (!r_half[0]) begin
            w_sclk_nxt = 1'b0;
            w_mosi_nxt = r_tx[6];
            w_tx_nxt   = {r_tx[6:0], 1'b0};
          end else begin
            w_sclk_nxt = 1'b1;
            w_rx_nxt   = {r_rx[6:0], w_rx_bit};
          end
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_ss_nxt    = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_byte = r_rx_byte;
  assign bus.SCLK    = r_sclk;
  assign bus.MOSI    = r_mosi;
  assign bus.SS      = r_ss;

endmodule

// File: tb/tb_m_spi_master.sv
// Bench for m_spi_master: cycle-by-cycle pin model derived from the timing rules plus a mode-0 slave.
module tb_m_spi_master;
  localparam int D = 4;

  logic clk = 1'b0;
  logic btn_reset = 1'b0;

  m_spi_master_if bus ();

  m_spi_master #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Slave: presents sl_tx MSB-first on MISO, collects MOSI at each SCLK rise.
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_sh = 8'h00;
  logic [2:0] sl_cnt = 3'd0;
  logic [7:0] sl_got[$];
  bit         miso_zero = 1'b0;

  assign bus.MISO = miso_zero ? 1'b0 : sl_tx[3'd7 - sl_cnt];

  always @(posedge bus.SCLK or posedge bus.SS) begin
    if (bus.SS) begin
      sl_cnt <= 3'd0;
    end else begin
      sl_sh  <= {sl_sh[6:0], bus.MOSI};
      sl_cnt <= sl_cnt + 3'd1;
      if (sl_cnt == 3'd7) sl_got.push_back({sl_sh[6:0], bus.MOSI});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check(tag, {bus.SS, bus.SCLK, bus.MOSI, bus.busy, bus.done, bus.rx_byte}, 32'h1000);
  endtask

  // Expected {SS,SCLK,MOSI,busy,done} n cycles after the accepting edge (n >= 1).
  function automatic logic [4:0] pins_exp(input int n, input logic [7:0] tx, input bit hold);
    int   j;
    logic ss, sclk, mosi, busy, done;
    j = (n - 1) / (2 * D);
    if (j > 7) j = 7;
    ss   = !(hold || (n < 1 + 17 * D));
    sclk = (n >= 1 + D) && (n < 1 + 17 * D) && ((((n - 1 - D) / D) % 2) == 0);
    mosi = tx[7 - j];
    busy = n < (hold ? 1 + 16 * D : 1 + 18 * D);
    done = (n == 1 + 16 * D);
    return {ss, sclk, mosi, busy, done};
  endfunction

  task automatic xfer(input logic [7:0] tx, input bit hold, input logic [7:0] ret,
                      input int inject, input int extra);
    int         last;
    logic [7:0] exp_rx;
    logic [7:0] got;
`ifdef M_SPI_LOOPBACK_EN
    exp_rx = tx;
`else
    exp_rx = miso_zero ? 8'h00 : ret;
`endif
    last = (hold ? 1 + 16 * D : 1 + 18 * D) + extra;
    sl_tx = ret;
    bus.tx_byte = tx;
    bus.hold_ss = hold;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      check($sformatf("pins{SS,SCLK,MOSI,busy,done} tx=%h n=%0d", tx, n),
            {bus.SS, bus.SCLK, bus.MOSI, bus.busy, bus.done}, pins_exp(n, tx, hold));
      if (n == 1 + 16 * D) check($sformatf("rx_byte tx=%h", tx), bus.rx_byte, exp_rx);
      if (n == inject) begin
        bus.start   = 1'b1;
        bus.tx_byte = 8'hFF;
        bus.hold_ss = 1'b0;
      end
    end
    check($sformatf("slave_byte_count tx=%h", tx), sl_got.size(), 1);
    got = (sl_got.size() > 0) ? sl_got.pop_front() : 8'hxx;
    check($sformatf("mosi_stream tx=%h", tx), got, tx);
    sl_got.delete();
  endtask

  initial begin : stim
    logic [7:0] frame [4];
    int   rises;
    logic prev;
    bit   h;
    frame[0] = 8'h46; frame[1] = 8'h52; frame[2] = 8'h4F; frame[3] = 8'h4D;
    bus.start = 1'b0;
    bus.tx_byte = 8'h00;
    bus.hold_ss = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check_reset("reset_values");
    @(negedge clk) btn_reset = 1'b1;
    @(posedge clk); #1;

    xfer(8'hA5, 1'b0, 8'h3C, 0, 2);

    for (int i = 0; i < 4; i++)
      xfer(frame[i], (i != 3), 8'($urandom), 0, (i == 3) ? 2 : 0);

    // Start pulse at T+10 during a transfer must be ignored.
    xfer(8'hA5, 1'b0, 8'($urandom), 9, 3);
    // Start present on the edge where busy falls must be ignored.
    xfer(8'($urandom), 1'b0, 8'($urandom), 1 + 18 * D - 1, 3);
    xfer(8'($urandom), 1'b1, 8'($urandom), 1 + 16 * D - 1, 0);
    xfer(8'($urandom), 1'b0, 8'($urandom), 0, 1);

    for (int i = 0; i < 8; i++) begin
      h = (i == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      xfer(8'($urandom), h, 8'($urandom), 0, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset after the 4th rising SCLK edge.
    sl_tx = 8'($urandom);
    bus.tx_byte = 8'hC3;
    bus.hold_ss = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rises = 0;
    prev = bus.SCLK;
    for (int n = 0; n < 200 && rises < 4; n++) begin
      @(posedge clk); #1;
      if (bus.SCLK && !prev) rises++;
      prev = bus.SCLK;
    end
    check("rises_before_reset", rises, 4);
    #2 btn_reset = 1'b0;
    #1;
    check_reset("reset_async_midxfer");
    repeat (3) @(posedge clk);
    @(negedge clk) btn_reset = 1'b1;
    @(posedge clk); #1;
    check("slave_partial_discard", sl_got.size(), 0);
    sl_got.delete();
    xfer(8'h81, 1'b0, 8'($urandom), 0, 2);

    miso_zero = 1'b1;
    xfer(8'h5A, 1'b0, 8'hFF, 0, 2);
    miso_zero = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
